// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - EX-stage branch/jump resolution with predictor feedback, shadow window and perf counters
module branch_resolver #(
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_WID       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               ex_branch,
    input  logic               ex_predict,
    input  logic               ex_ujtype,
    input  logic               ex_jalr,
    input  logic [2:0]         ex_funct3,
    input  logic               ex_pred_taken,
    input  logic [31:0]        ex_pred_target,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ex_imm,
    input  logic [31:0]        rs1_data,
    input  logic [31:0]        rs2_data,
    input  logic               stat_clear,
    output logic               fb_branch,
    output logic               fb_predict,
    output logic               fb_actual,
    output logic [31:0]        fb_pc,
    output logic               mispredict,
    output logic               in_shadow,
    output logic [CNT_WID-1:0] br_count,
    output logic [CNT_WID-1:0] miss_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } state_t;

    localparam logic [CNT_WID-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [2:0]         shadow_cnt_q, shadow_cnt_d;
    logic               fb_branch_q, fb_branch_d;
    logic               fb_predict_q, fb_predict_d;
    logic               fb_actual_q, fb_actual_d;
    logic [31:0]        fb_pc_q, fb_pc_d;
    logic               mispredict_q, mispredict_d;
    logic [CNT_WID-1:0] br_count_q, br_count_d;
    logic [CNT_WID-1:0] miss_count_q, miss_count_d;

    logic        cond;
    logic        actual;
    logic [31:0] target;
    logic        miss_now;
    logic        accept;

    // Evaluate the branch condition selected by funct3; unused encodings resolve not-taken
    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = (rs1_data == rs2_data);
            3'b001:  cond = (rs1_data != rs2_data);
            3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond = (rs1_data <  rs2_data);
            3'b111:  cond = (rs1_data >= rs2_data);
            default: cond = 1'b0;
        endcase
    end

    // Resolve direction and correct next PC, then compare against the front end's guess
    always_comb begin
        actual = ex_ujtype | ex_jalr | cond;
        if (ex_jalr) begin
            target = (rs1_data + ex_imm) & ~32'd1;
        end else if (actual) begin
            target = ex_pc + ex_imm;
        end else begin
            target = ex_pc + 32'd4;
        end
        // A taken branch fetched down the wrong target is as bad as a wrong direction
        miss_now = (ex_pred_taken != actual) | (actual & (ex_pred_target != target));
        accept   = ex_valid & ex_branch & (state_q == IDLE);
    end

    // Next-state for the shadow FSM, feedback set and saturating counters
    always_comb begin
        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && miss_now) begin
                    state_d      = SHADOW;
                    shadow_cnt_d = 3'(SHADOW_CYCLES);
                end
            end
            SHADOW: begin
                shadow_cnt_d = shadow_cnt_q - 3'd1;
                if (shadow_cnt_d == 3'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        fb_branch_d  = accept & ex_predict;
        fb_actual_d  = accept & actual;
        // Inverting on a miss makes any downstream predict!=actual check redirect
        fb_predict_d = accept & (miss_now ? ~actual : actual);
        mispredict_d = accept & miss_now;
        fb_pc_d      = accept ? target : fb_pc_q;

        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (stat_clear) begin
            br_count_d   = '0;
            miss_count_d = '0;
        end else begin
            if (accept && (br_count_q != CNT_MAX)) begin
                br_count_d = br_count_q + CNT_WID'(1);
            end
            if (accept && miss_now && (miss_count_q != CNT_MAX)) begin
                miss_count_d = miss_count_q + CNT_WID'(1);
            end
        end
    end

    // Register state and all outputs; reset drops any pending pulse and clears counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shadow_cnt_q <= 3'd0;
            fb_branch_q  <= 1'b0;
            fb_predict_q <= 1'b0;
            fb_actual_q  <= 1'b0;
            fb_pc_q      <= 32'd0;
            mispredict_q <= 1'b0;
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shadow_cnt_q <= shadow_cnt_d;
            fb_branch_q  <= fb_branch_d;
            fb_predict_q <= fb_predict_d;
            fb_actual_q  <= fb_actual_d;
            fb_pc_q      <= fb_pc_d;
            mispredict_q <= mispredict_d;
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign fb_branch  = fb_branch_q;
    assign fb_predict = fb_predict_q;
    assign fb_actual  = fb_actual_q;
    assign fb_pc      = fb_pc_q;
    assign mispredict = mispredict_q;
    assign in_shadow  = (state_q == SHADOW);
    assign br_count   = br_count_q;
    assign miss_count = miss_count_q;

endmodule
